// File: rtl/mc14433_frame_reader.sv
`default_nettype none
// mc14433_frame_reader: synchronises the MC14433 digit-strobe/BCD port and publishes
// validated frames as digits, flags and an 11-bit magnitude. Rev 1.0
module mc14433_frame_reader #(
  parameter int TIMEOUT = 4096,
  parameter int CW      = 13
) (
  input  logic        CP0,
  input  logic        R_clock,
  input  logic        eoc,
  input  logic [3:0]  ds,
  input  logic [3:0]  q,
  output logic        msd,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd4,
  output logic        pos,
  output logic        over_range,
  output logic        under_range,
  output logic [10:0] magnitude,
  output logic        data_valid,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, WAIT1, WAIT2, WAIT3, WAIT4, PUBLISH} state_t;

  state_t        state, state_nx;
  logic          eoc_s1, eoc_s2, eoc_p;
  logic [3:0]    ds_s1, ds_s2, ds_p;
  logic [3:0]    q_s1, q_s2;
  logic [CW-1:0] timer;
  logic          sh_msd, sh_pos, sh_over, sh_under;
  logic [3:0]    sh_b2, sh_b3, sh_b4;
  logic          eoc_rise, err, take, clr_timer, in_wait;
  logic [3:0]    ds_rise, want;
  logic [10:0]   d2, d3, d4, mag_calc;

  always_ff @(posedge CP0 or negedge R_clock) begin
    if (!R_clock) begin
      eoc_s1 <= 1'b0; eoc_s2 <= 1'b0; eoc_p <= 1'b0;
      ds_s1  <= 4'd0; ds_s2  <= 4'd0; ds_p  <= 4'd0;
      q_s1   <= 4'd0; q_s2   <= 4'd0;
    end else begin
      eoc_s1 <= eoc;   eoc_s2 <= eoc_s1; eoc_p <= eoc_s2;
      ds_s1  <= ds;    ds_s2  <= ds_s1;  ds_p  <= ds_s2;
      q_s1   <= q;     q_s2   <= q_s1;
    end
  end

  assign eoc_rise = eoc_s2 & ~eoc_p;
  assign ds_rise  = ds_s2 & ~ds_p;
  assign in_wait  = (state == WAIT1) || (state == WAIT2) || (state == WAIT3) || (state == WAIT4);

  always_comb begin
    state_nx  = state;
    err       = 1'b0;
    take      = 1'b0;
    clr_timer = 1'b0;
    want      = 4'd0;
    case (state)
      WAIT1:   want = 4'b0001;
      WAIT2:   want = 4'b0010;
      WAIT3:   want = 4'b0100;
      WAIT4:   want = 4'b1000;
      default: want = 4'd0;
    endcase
    case (state)
      IDLE: begin
        if (eoc_rise) begin
          state_nx  = WAIT1;
          clr_timer = 1'b1;
        end
      end
      PUBLISH: state_nx = IDLE;
      default: begin
        // A fresh conversion silently abandons the partial frame.
        if (eoc_rise) begin
          state_nx  = WAIT1;
          clr_timer = 1'b1;
        end else if (ds_rise != 4'd0) begin
          // Any mismatch (wrong strobe or several at once) is an order error.
          if (ds_rise != want) err = 1'b1;
          else if ((state != WAIT1) && (q_s2 > 4'd9)) err = 1'b1;
          else begin
            take = 1'b1;
            case (state)
              WAIT1:   state_nx = WAIT2;
              WAIT2:   state_nx = WAIT3;
              WAIT3:   state_nx = WAIT4;
              default: state_nx = PUBLISH;
            endcase
          end
        end else if (timer == CW'(TIMEOUT)) begin
          err = 1'b1;
        end
        if (err) state_nx = IDLE;
      end
    endcase
  end

  assign d2 = {7'd0, sh_b2};
  assign d3 = {7'd0, sh_b3};
  assign d4 = {7'd0, sh_b4};
  assign mag_calc = (sh_msd ? 11'd1000 : 11'd0)
                  + (d2 << 6) + (d2 << 5) + (d2 << 2)
                  + (d3 << 3) + (d3 << 1) + d4;

  always_ff @(posedge CP0 or negedge R_clock) begin
    if (!R_clock) begin
      state      <= IDLE;
      timer      <= '0;
      sh_msd     <= 1'b0; sh_pos <= 1'b1; sh_over <= 1'b0; sh_under <= 1'b0;
      sh_b2      <= 4'd0; sh_b3  <= 4'd0; sh_b4   <= 4'd0;
      msd        <= 1'b0; pos    <= 1'b1;
      bcd2       <= 4'd0; bcd3   <= 4'd0; bcd4    <= 4'd0;
      over_range <= 1'b0; under_range <= 1'b0;
      magnitude  <= 11'd0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      data_valid <= (state == PUBLISH);
      frame_err  <= err;
      if (clr_timer || take || !in_wait) timer <= '0;
      else                               timer <= timer + 1'b1;
      if (take) begin
        case (state)
          WAIT1: begin
            sh_msd   <= ~q_s2[3];
            sh_pos   <= q_s2[2];
            sh_over  <= q_s2[0] & ~q_s2[3];
            sh_under <= q_s2[0] & q_s2[3];
          end
          WAIT2:   sh_b2 <= q_s2;
          WAIT3:   sh_b3 <= q_s2;
          default: sh_b4 <= q_s2;
        endcase
      end
      if (state == PUBLISH) begin
        msd         <= sh_msd;
        pos         <= sh_pos;
        over_range  <= sh_over;
        under_range <= sh_under;
        bcd2        <= sh_b2;
        bcd3        <= sh_b3;
        bcd4        <= sh_b4;
        magnitude   <= mag_calc;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mc14433_frame_reader.sv
`default_nettype none
// tb_mc14433_frame_reader: directed frames with a scoreboard of expected published readings.
module tb_mc14433_frame_reader;

  logic        CP0 = 1'b0;
  logic        R_clock;
  logic        eoc;
  logic [3:0]  ds;
  logic [3:0]  q;
  logic        msd, pos, over_range, under_range, data_valid, frame_err, busy;
  logic [3:0]  bcd2, bcd3, bcd4;
  logic [10:0] magnitude;

  int npass = 0;
  int ntotal = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;

  typedef struct {
    logic        msd;
    logic [3:0]  b2, b3, b4;
    logic        pos, ov, un;
    logic [10:0] mag;
  } exp_t;
  exp_t sb[$];

  mc14433_frame_reader #(.TIMEOUT(16), .CW(5)) dut (
    .CP0(CP0), .R_clock(R_clock), .eoc(eoc), .ds(ds), .q(q),
    .msd(msd), .bcd2(bcd2), .bcd3(bcd3), .bcd4(bcd4), .pos(pos),
    .over_range(over_range), .under_range(under_range), .magnitude(magnitude),
    .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 CP0 = ~CP0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CP0);
    #1;
  endtask

  task automatic push(input logic m, input logic [3:0] b2, input logic [3:0] b3,
                      input logic [3:0] b4, input logic p, input logic ov,
                      input logic un, input logic [10:0] mag);
    exp_t e;
    e.msd = m; e.b2 = b2; e.b3 = b3; e.b4 = b4;
    e.pos = p; e.ov = ov; e.un = un; e.mag = mag;
    sb.push_back(e);
  endtask

  task automatic pulse_eoc();
    eoc = 1'b1; tick(4);
    eoc = 1'b0; tick(3);
  endtask

  task automatic strobe(input int idx, input logic [3:0] v);
    q = v; tick(1);
    ds[idx] = 1'b1; tick(4);
    ds[idx] = 1'b0; tick(4);
  endtask

  task automatic frame(input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] s3, input logic [3:0] s4);
    pulse_eoc();
    strobe(0, s1); strobe(1, s2); strobe(2, s3); strobe(3, s4);
    tick(3);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_msd"}, msd, 0);
    check({tag, "_bcd"}, {bcd2, bcd3, bcd4}, 0);
    check({tag, "_mag"}, magnitude, 0);
    check({tag, "_pos"}, pos, 1);
    check({tag, "_range"}, {over_range, under_range}, 0);
    check({tag, "_pulses"}, {data_valid, frame_err}, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  always @(negedge CP0) begin
    if (data_valid) begin
      exp_t e;
      dv_cnt++;
      check("sb_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pub_msd", msd, e.msd);
        check("pub_digits", {bcd2, bcd3, bcd4}, {e.b2, e.b3, e.b4});
        check("pub_pos", pos, e.pos);
        check("pub_over", over_range, e.ov);
        check("pub_under", under_range, e.un);
        check("pub_mag", magnitude, e.mag);
      end
    end
    if (frame_err) begin
      fe_cnt++;
      check("dv_fe_exclusive", data_valid, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, dv0, n;
    R_clock = 1'b0; eoc = 1'b0; ds = 4'd0; q = 4'd0;
    tick(2);
    check_reset_values("reset");
    R_clock = 1'b1;
    tick(2);

    // Clean frame with exact DS4-to-data_valid latency
    push(1, 9, 9, 9, 1, 0, 0, 11'd1999);
    pulse_eoc();
    check("busy_wait1", busy, 1);
    strobe(0, 4'b0100); strobe(1, 4'd9); strobe(2, 4'd9);
    q = 4'd9; tick(1);
    ds[3] = 1'b1;
    repeat (3) @(posedge CP0);
    @(negedge CP0); check("lat_dv_early", data_valid, 0);
    @(negedge CP0); check("lat_dv_at4", data_valid, 1);
    @(negedge CP0); check("lat_dv_one_cycle", data_valid, 0);
    ds[3] = 1'b0; tick(4);
    check("clean_mag", magnitude, 1999);
    check("clean_busy_low", busy, 0);

    // Negative, under-range
    push(0, 1, 5, 0, 0, 0, 1, 11'd150);
    frame(4'b1001, 4'd1, 4'd5, 4'd0);

    // Out-of-order strobes
    fe0 = fe_cnt;
    pulse_eoc();
    strobe(0, 4'b1100); strobe(2, 4'd2);
    check("order_fe", fe_cnt, fe0 + 1);
    check("order_keep_mag", magnitude, 150);
    check("order_keep_flags", {pos, under_range}, 2'b01);
    check("order_busy", busy, 0);

    // Invalid BCD then good frame 0,1,2,3
    fe0 = fe_cnt;
    pulse_eoc();
    strobe(0, 4'b1100); strobe(1, 4'd1); strobe(2, 4'hB);
    check("bcd_fe", fe_cnt, fe0 + 1);
    check("bcd_busy", busy, 0);
    push(0, 1, 2, 3, 1, 0, 0, 11'd123);
    frame(4'b1100, 4'd1, 4'd2, 4'd3);
    check("bcd_next_mag", magnitude, 123);

    // Timeout after DS1
    fe0 = fe_cnt;
    pulse_eoc();
    strobe(0, 4'b0100);
    n = 0;
    while (fe_cnt == fe0 && n < 40) begin
      tick(1);
      n++;
    end
    check("timeout_fe", fe_cnt, fe0 + 1);
    check("timeout_not_early", n > 5, 1);
    push(1, 0, 4, 2, 1, 0, 0, 11'd1042);
    frame(4'b0100, 4'd0, 4'd4, 4'd2);

    // eoc restart mid-frame, then over-range frame
    fe0 = fe_cnt;
    pulse_eoc();
    strobe(0, 4'b0000); strobe(1, 4'd7);
    push(1, 0, 0, 5, 0, 1, 0, 11'd1005);
    frame(4'b0001, 4'd0, 4'd0, 4'd5);
    check("restart_no_fe", fe_cnt, fe0);

    // Reset between DS3 and DS4
    pulse_eoc();
    strobe(0, 4'b0100); strobe(1, 4'd3); strobe(2, 4'd3);
    dv0 = dv_cnt; fe0 = fe_cnt;
    R_clock = 1'b0;
    #1;
    check_reset_values("midreset");
    tick(2);
    R_clock = 1'b1;
    tick(1);
    strobe(3, 4'd3);
    tick(5);
    check("midreset_no_dv", dv_cnt, dv0);
    check("midreset_no_fe", fe_cnt, fe0);
    check("midreset_mag", magnitude, 0);
    check("midreset_busy", busy, 0);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire
